// File: rtl/binary_to_bcd_sequential.sv
// Iterative double-dabble (shift-and-add-3) binary to packed BCD converter.
// One conversion per start pulse, WIDTH shift steps, followed by a one-cycle
// done pulse. Also produces a leading-zero blank mask for the display.
//
// Handshake: start is sampled only while idle (busy=0). The edge that samples
// start=1 captures binary and raises busy. busy falls on the edge that
// publishes bcd/blank, and done is high for exactly that following cycle.
// start during busy is dropped, not queued. start while done=1 is accepted.
module binary_to_bcd_sequential #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned DEC_RANGE = pow10(DIGITS);

  // The digit count must be able to hold the largest input value.
  generate
    if (DEC_RANGE <= MAX_BIN) begin : g_digits_too_small
      $fatal(1, "binary_to_bcd_sequential: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t                state;
  logic [WIDTH-1:0]      shift_reg;
  logic [4*DIGITS-1:0]   scratch;
  logic [CW-1:0]         count;

  logic [4*DIGITS-1:0]   adjusted;
  logic [4*DIGITS-1:0]   scratch_next;
  logic [WIDTH-1:0]      shift_next;
  logic [DIGITS-1:0]     blank_next;
  logic                  zero_above;

  assign fsm_state = state;

  // One double-dabble step: add 3 to every digit >= 5, then shift left by one
  // with the binary MSB entering the units digit. A digit is < 10 before the
  // add, so the 4-bit add never carries out.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      else
        adjusted[4*i +: 4] = scratch[4*i +: 4];
    end
    scratch_next = {adjusted[4*DIGITS-2:0], shift_reg[WIDTH-1]};
    shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
  end

  // Leading-zero mask of the post-step value: digit i blanks when it and all
  // higher digits are zero. The units digit is never blanked.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (scratch_next[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  // Control FSM with registered outputs; bcd/blank only change on completion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      blank     <= BLANK_RST;
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= binary;
            scratch   <= '0;
            count     <= CW'(WIDTH);
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_next;
          count     <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd   <= scratch_next;
            blank <= blank_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_sequential.sv
// Bench for binary_to_bcd_sequential: directed conversions, handshake timing,
// mid-conversion reset and a back-to-back sweep of every 8-bit value.
module tb_binary_to_bcd_sequential;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int RW     = 4*DIGITS + DIGITS;

  logic                clock;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    binary;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic                fsm_state;

  logic [RW-1:0] exp_q[$];
  int checks;
  int errors;
  logic prev_done;

  binary_to_bcd_sequential #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .binary    (binary),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .blank     (blank),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: decimal digits by division, blank from digit values.
  function automatic logic [RW-1:0] ref_model(input int v);
    logic [3:0] d0, d1, d2;
    logic [2:0] bl;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'(v / 100);
    bl[2] = (d2 == 4'd0);
    bl[1] = (d2 == 4'd0) && (d1 == 4'd0);
    bl[0] = 1'b0;
    return {d2, d1, d0, bl};
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Monitor: pop and compare whenever done is presented.
  always @(negedge clock) begin
    if (done) begin
      check("done_with_busy", int'(busy), 0);
      check("done_two_cycles", int'(prev_done), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got bcd 0x%0h, expected no result", bcd);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("bcd", int'(bcd), int'(e[RW-1:DIGITS]));
        check("blank", int'(blank), int'(e[DIGITS-1:0]));
      end
    end
    prev_done = done;
  end

  // Driver: issue one conversion and wait (bounded) for its done.
  task automatic convert(input int v, input logic [11:0] eb, input logic [2:0] ebl);
    int n;
    @(negedge clock);
    start  = 1'b1;
    binary = WIDTH'(v);
    exp_q.push_back({eb, ebl});
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  initial begin
    int busy_cycles;
    int done_at;
    int n;
    checks = 0;
    errors = 0;
    prev_done = 1'b0;
    reset  = 1'b0;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bcd", int'(bcd), 'h000);
    check("reset_blank", int'(blank), 3'b110);
    reset = 1'b1;

    // Directed conversions
    convert(0,   12'h000, 3'b110);
    convert(255, 12'h255, 3'b000);
    convert(225, 12'h225, 3'b000);
    convert(63,  12'h063, 3'b100);
    convert(9,   12'h009, 3'b110);
    convert(100, 12'h100, 3'b000);
    convert(99,  12'h099, 3'b100);

    // Timing: busy exactly 8 cycles, done after edge N+8, start at N+3 ignored
    @(negedge clock);
    start  = 1'b1;
    binary = 8'd200;
    exp_q.push_back({12'h200, 3'b000});
    busy_cycles = 0;
    done_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; binary = 8'd42; end
      if (i == 4) start = 1'b0;
      if (busy) busy_cycles++;
      if (done && done_at < 0) done_at = i;
    end
    check("busy_cycles", busy_cycles, 8);
    check("done_cycle", done_at, 9);

    // Reset mid-conversion: no done, outputs back to reset values
    @(negedge clock);
    start  = 1'b1;
    binary = 8'd77;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      if (i == 1) start = 1'b0;
      if (i == 4) reset = 1'b0;
    end
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bcd", int'(bcd), 'h000);
    check("abort_blank", int'(blank), 3'b110);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    convert(128, 12'h128, 3'b000);

    // Back-to-back sweep with start held high
    for (int v = 0; v < 256; v++) begin
      if (v != 0) binary = WIDTH'(v);
      else begin
        @(negedge clock);
        start  = 1'b1;
        binary = '0;
      end
      exp_q.push_back(ref_model(v));
      repeat (9) @(negedge clock);
    end
    start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    repeat (12) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_sequential.md
Name: binary_to_bcd_sequential

Overview:
Iterative double-dabble (shift-and-add-3) converter between the 4x4 multiplier's 8-bit product and the four-digit seven-segment display. It accepts one binary word per start pulse and converts it in WIDTH shift cycles. It then presents packed BCD digits plus a leading-zero blank mask that the display wiring consumes. A start/busy/done handshake lets a controller sample the multiplier output and know when the digits are valid.

Parameters:
WIDTH, 8, bit width of the binary input.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1, checked at elaboration with a fatal error if violated.

Ports:
clock  input  1  single system clock; all state changes on its rising edge
reset  input  1  synchronous, active-low reset: 0 sampled on a rising edge resets the block
start  input  1  request conversion of binary; sampled only in IDLE
binary  input  WIDTH  unsigned value to convert; sampled on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd and blank were just updated
bcd  output  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 = units
blank  output  DIGITS  bit i high when digit i is a leading zero; bit 0 is always 0

Behaviour:
- Reset values, applied when reset=0 at a clock edge:
  - state=IDLE, busy=0, done=0, bcd=0
  - blank = all ones except bit 0, so 0 displays as a single "0"
  - scratch registers and counter cleared
- Reset has priority over every other input. A reset during conversion aborts it: no done pulse, and bcd/blank take their reset values.
- Internal registers: shift register of WIDTH bits, BCD scratch of 4*DIGITS bits, cycle counter of clog2(WIDTH+1) bits.
- State IDLE:
  - start=1 at edge N: latch binary into the shift register, clear the scratch, set counter=WIDTH, go to CONVERT. busy=1 from after edge N.
  - start=0: remain in IDLE.
- State CONVERT, one step per edge:
  - Every scratch digit >= 5 gets +3, all digits in parallel (combinational).
  - {scratch, shift} shifts left by 1; the shift register MSB enters scratch bit 0.
  - Counter decrements by 1.
- Completion at edge N+WIDTH (the step where counter goes 1 -> 0):
  - bcd <= final scratch value including that step's shift.
  - blank recomputed: bit i = 1 iff digit i and all higher digits are zero, for i >= 1.
  - done=1 and busy=0 during the following cycle; state returns to IDLE.
- Latency: start accepted at edge N gives results visible after edge N+WIDTH (8 cycles by default). Throughput is one conversion per WIDTH+1 cycles.
- start while busy=1 is ignored and not queued. binary changes during CONVERT have no effect.
- start=1 in the cycle where done=1 is legal: the state is IDLE, so it is accepted (back-to-back operation).
- bcd and blank hold their last value between completions. They never show intermediate scratch values.
- done is never high for two consecutive cycles, and done and busy are never high together.
- Each add-3 is 4-bit with no carry out, since a digit is < 10 before the add. The scratch never exceeds 9 per digit after the shift.
- Display hookup (outside this block): digit_1..digit_3 take bcd digits 2..0 and digit_4 = 0, or the blank mask selects the blank pattern.

Test Plan:
- Reset release, then start with binary=0 -> after 8 cycles done pulses once; bcd=12'h000, blank=3'b110.
- binary=255 (15*15 = 225 checked separately) -> bcd=12'h255, blank=3'b000. 225 -> bcd=12'h225.
- Multiplier product 7*9=63 -> bcd=12'h063, blank=3'b100. binary=9 -> bcd=12'h009, blank=3'b110. binary=100 -> bcd=12'h100, blank=3'b000.
- Timing check: start at edge N -> busy high for exactly 8 cycles, done high only in the cycle after edge N+8. A second start at N+3 with binary=42 is ignored; the result stays that of the first value.
- reset=0 asserted at edge N+4 mid-conversion -> no done; bcd=0, blank=3'b110, busy=0 the next cycle. A new start after release converts correctly.
- Back-to-back: start held high continuously with binary stepping 0..255 -> each done carries the correct BCD of the value sampled at its accept edge. Exhaustive compare against a reference model, one accept every 9 cycles.
